// File: rtl/rv32im_lsu_ctrl_pkg.sv
// Shared definitions for the RV32IM load/store unit controller:
// bus widths, LSU opcode encodings, FSM state encoding and opcode helpers.
package rv32im_lsu_ctrl_pkg;

    localparam int API_DATA_WIDTH   = 32;
    localparam int API_ADDR_WIDTH   = 32;
    localparam int LSU_OPCODE_WIDTH = 4;

    // Opcode 0 (and anything above SW) is deliberately not a memory op.
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_NONE = 4'd0;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LB   = 4'd1;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LBU  = 4'd2;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LH   = 4'd3;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LHU  = 4'd4;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LW   = 4'd5;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SB   = 4'd6;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SH   = 4'd7;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // True for any of the eight load/store opcodes.
    function automatic logic lsu_op_valid(input logic [LSU_OPCODE_WIDTH-1:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for the three store opcodes.
    function automatic logic lsu_op_store(input logic [LSU_OPCODE_WIDTH-1:0] op);
        logic st;
        case (op)
            OP_SB, OP_SH, OP_SW: st = 1'b1;
            default:             st = 1'b0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rv32im_lsu_lane.sv
// Byte-lane steering for the LSU: byte enables, store-data replication,
// load-data alignment with sign/zero extension and misalignment detection.
// Purely combinational.
module rv32im_lsu_lane
    import rv32im_lsu_ctrl_pkg::*;
(
    input  logic [LSU_OPCODE_WIDTH-1:0] opcode,
    input  logic [1:0]                  addr_lo,
    input  logic [API_DATA_WIDTH-1:0]   wdata,
    input  logic [API_DATA_WIDTH-1:0]   rdata,
    output logic [3:0]                  be,
    output logic [API_DATA_WIDTH-1:0]   wdata_lane,
    output logic [API_DATA_WIDTH-1:0]   rdata_ext,
    output logic                        op_valid,
    output logic                        is_store,
    output logic                        misaligned
);

    logic [API_DATA_WIDTH-1:0] rdata_shift_s;

    // Decode opcode and low address bits into lane controls and aligned data.
    always_comb begin
        rdata_shift_s = rdata >> {addr_lo, 3'b000};
        be            = 4'b0000;
        wdata_lane    = '0;
        rdata_ext     = '0;
        misaligned    = 1'b0;
        op_valid      = lsu_op_valid(opcode);
        is_store      = lsu_op_store(opcode);
        case (opcode)
            OP_LB: begin
                be        = 4'b0001 << addr_lo;
                rdata_ext = {{24{rdata_shift_s[7]}}, rdata_shift_s[7:0]};
            end
            OP_LBU: begin
                be        = 4'b0001 << addr_lo;
                rdata_ext = {24'h000000, rdata_shift_s[7:0]};
            end
            OP_LH: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
                rdata_ext  = {{16{rdata_shift_s[15]}}, rdata_shift_s[15:0]};
            end
            OP_LHU: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
                rdata_ext  = {16'h0000, rdata_shift_s[15:0]};
            end
            OP_LW: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
                rdata_ext  = rdata;
            end
            OP_SB: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            OP_SH: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
                wdata_lane = {2{wdata[15:0]}};
            end
            OP_SW: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
                wdata_lane = wdata;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = '0;
                rdata_ext  = '0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32im_lsu_ctrl.sv
// RV32IM load/store controller: accepts one access from the EXU, drives a
// simple req/ack memory bus with a bounded wait, and returns the extended
// load result with a one-cycle done pulse. All outputs are registered.
module rv32im_lsu_ctrl
    import rv32im_lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        lsu_valid_i,
    input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
    input  logic [API_ADDR_WIDTH-1:0]   addr_mem_i,
    input  logic [API_DATA_WIDTH-1:0]   val_memwr_i,
    output logic                        lsu_ready_o,
    output logic                        lsu_busy_o,
    output logic                        lsu_done_o,
    output logic                        lsu_err_o,
    output logic [API_DATA_WIDTH-1:0]   val_memrd_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [3:0]                  mem_be_o,
    output logic [API_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [API_DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                        mem_ack_i,
    input  logic [API_DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e                  state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [LSU_OPCODE_WIDTH-1:0] op_r;
    logic [1:0]                  addr_lo_r;

    logic                        ready_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        err_r;
    logic [API_DATA_WIDTH-1:0]   rd_r;
    logic                        req_r;
    logic                        we_r;
    logic [3:0]                  be_r;
    logic [API_ADDR_WIDTH-1:0]   addr_r;
    logic [API_DATA_WIDTH-1:0]   wdata_r;

    logic [LSU_OPCODE_WIDTH-1:0] sel_op_s;
    logic [1:0]                  sel_addr_lo_s;
    logic [3:0]                  lane_be_s;
    logic [API_DATA_WIDTH-1:0]   lane_wdata_s;
    logic [API_DATA_WIDTH-1:0]   lane_rdata_s;
    logic                        lane_op_valid_s;
    logic                        lane_is_store_s;
    logic                        lane_misaligned_s;

    // One lane decoder serves both phases: incoming request while idle,
    // latched request while waiting for the read data.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_op_s      = lsu_opcode_i;
            sel_addr_lo_s = addr_mem_i[1:0];
        end else begin
            sel_op_s      = op_r;
            sel_addr_lo_s = addr_lo_r;
        end
    end

    rv32im_lsu_lane u_lane (
        .opcode     (sel_op_s),
        .addr_lo    (sel_addr_lo_s),
        .wdata      (val_memwr_i),
        .rdata      (mem_rdata_i),
        .be         (lane_be_s),
        .wdata_lane (lane_wdata_s),
        .rdata_ext  (lane_rdata_s),
        .op_valid   (lane_op_valid_s),
        .is_store   (lane_is_store_s),
        .misaligned (lane_misaligned_s)
    );

    // Access FSM with timeout counter; every output is a register updated here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            op_r      <= OP_NONE;
            addr_lo_r <= 2'b00;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rd_r      <= '0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            be_r      <= 4'b0000;
            addr_r    <= '0;
            wdata_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    rd_r   <= '0;
                    if (lsu_valid_i && lane_op_valid_s) begin
                        op_r      <= lsu_opcode_i;
                        addr_lo_r <= addr_mem_i[1:0];
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        if (lane_misaligned_s) begin
                            // Never reaches the bus; report straight away.
                            state_r <= ST_RESP;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            state_r <= ST_REQ;
                            cnt_r   <= '0;
                            req_r   <= 1'b1;
                            we_r    <= lane_is_store_s;
                            be_r    <= lane_be_s;
                            addr_r  <= {addr_mem_i[API_ADDR_WIDTH-1:2], 2'b00};
                            wdata_r <= lane_wdata_s;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack_i || (cnt_r == CNT_LAST)) begin
                        // An ack in the final allowed cycle still wins.
                        state_r <= ST_RESP;
                        done_r  <= 1'b1;
                        err_r   <= ~mem_ack_i;
                        if (mem_ack_i && !lane_is_store_s) begin
                            rd_r <= lane_rdata_s;
                        end else begin
                            rd_r <= '0;
                        end
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                        be_r    <= 4'b0000;
                        addr_r  <= '0;
                        wdata_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    rd_r    <= '0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    rd_r    <= '0;
                    req_r   <= 1'b0;
                    we_r    <= 1'b0;
                    be_r    <= 4'b0000;
                    addr_r  <= '0;
                    wdata_r <= '0;
                end
            endcase
        end
    end

    assign lsu_ready_o = ready_r;
    assign lsu_busy_o  = busy_r;
    assign lsu_done_o  = done_r;
    assign lsu_err_o   = err_r;
    assign val_memrd_o = rd_r;
    assign mem_req_o   = req_r;
    assign mem_we_o    = we_r;
    assign mem_be_o    = be_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_rv32im_lsu_ctrl.sv
// Self-checking bench for rv32im_lsu_ctrl: directed scenarios plus a
// randomized transaction loop compared against an arithmetic reference model.
module tb_rv32im_lsu_ctrl;
    import rv32im_lsu_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready, busy, done, err;
    logic [31:0] rdval;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    rv32im_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .lsu_valid_i(valid), .lsu_opcode_i(opcode),
        .addr_mem_i(addr), .val_memwr_i(wdata), .lsu_ready_o(ready),
        .lsu_busy_o(busy), .lsu_done_o(done), .lsu_err_o(err),
        .val_memrd_o(rdval), .mem_req_o(req), .mem_we_o(we), .mem_be_o(be),
        .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_ack_i(ack),
        .mem_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction
    function automatic bit m_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction
    function automatic int m_size(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction
    function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
        return (a % m_size(op)) != 0;
    endfunction
    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int s = m_size(op);
        if (s == 1) return 4'(1 << (a % 4));
        if (s == 2) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction
    function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] d);
        if (op == OP_SB) return (d % 256) * 32'h01010101;
        if (op == OP_SH) return (d % 65536) * 32'h00010001;
        if (op == OP_SW) return d;
        return 32'd0;
    endfunction
    function automatic logic [31:0] m_rd(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] r);
        int unsigned sh = r >> (8 * (a % 4));
        int b = int'(sh % 256);
        int h = int'(sh % 65536);
        if (op == OP_LB)  return (b >= 128) ? 32'(b - 256) : 32'(b);
        if (op == OP_LBU) return 32'(b);
        if (op == OP_LH)  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
        if (op == OP_LHU) return 32'(h);
        if (op == OP_LW)  return r;
        return 32'd0;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; step(); step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if ({busy, done, err, req, we} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, done, err, req, we}); end
        checks++; if ({be, maddr, mwdata, rdval} !== 100'd0) begin errors++; $display("FAIL reset_buses got %h exp 0", {be, maddr, mwdata, rdval}); end
        rst = 1'b0; step();
    endtask

    task automatic test_lb_directed();
        valid = 1'b1; opcode = OP_LB; addr = 32'h1003; step();
        valid = 1'b0;
        checks++; if ({req, we, be} !== 6'b10_1000) begin errors++; $display("FAIL lb_req got %b exp 101000", {req, we, be}); end
        checks++; if (maddr !== 32'h1000) begin errors++; $display("FAIL lb_addr got %h exp 1000", maddr); end
        ack = 1'b1; rdata = 32'h80AABBCC; step(); ack = 1'b0;
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL lb_done got %b exp 10", {done, err}); end
        checks++; if (rdval !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", rdval); end
        step();
        checks++; if ({done, ready, rdval} !== {2'b01, 32'd0}) begin errors++; $display("FAIL lb_after got %h exp 1_00000000", {done, ready, rdval}); end
    endtask

    task automatic test_sh_directed();
        valid = 1'b1; opcode = OP_SH; addr = 32'h2002; wdata = 32'h0000BEEF; step();
        valid = 1'b0;
        checks++; if ({req, we, be} !== 6'b11_1100) begin errors++; $display("FAIL sh_req got %b exp 111100", {req, we, be}); end
        checks++; if (mwdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", mwdata); end
        checks++; if (maddr !== 32'h2000) begin errors++; $display("FAIL sh_addr got %h exp 2000", maddr); end
        ack = 1'b1; step(); ack = 1'b0;
        checks++; if ({done, err, rdval} !== {2'b10, 32'd0}) begin errors++; $display("FAIL sh_done got %h exp 2_00000000", {done, err, rdval}); end
        step();
    endtask

    task automatic test_misaligned();
        valid = 1'b1; opcode = OP_LW; addr = 32'h3001; step();
        valid = 1'b0;
        checks++; if ({req, done, err} !== 3'b011) begin errors++; $display("FAIL mis_flags got %b exp 011", {req, done, err}); end
        checks++; if (rdval !== 32'd0) begin errors++; $display("FAIL mis_data got %h exp 0", rdval); end
        step();
        checks++; if ({ready, done} !== 2'b10) begin errors++; $display("FAIL mis_after got %b exp 10", {ready, done}); end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        valid = 1'b1; opcode = OP_LHU; addr = 32'h0; step();
        valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!req) break;
            cnt++;
            step();
        end
        checks++; if (cnt !== TO) begin errors++; $display("FAIL to_req_cycles got %0d exp %0d", cnt, TO); end
        checks++; if ({done, err, req} !== 3'b110) begin errors++; $display("FAIL to_done got %b exp 110", {done, err, req}); end
        step();
        checks++; if ({ready, done} !== 2'b10) begin errors++; $display("FAIL to_after got %b exp 10", {ready, done}); end
    endtask

    task automatic test_invalid_op();
        valid = 1'b1; opcode = 4'hF; addr = 32'h40; step();
        valid = 1'b0;
        checks++; if ({ready, busy, req, done} !== 4'b1000) begin errors++; $display("FAIL badop got %b exp 1000", {ready, busy, req, done}); end
    endtask

    task automatic test_reset_mid_req();
        valid = 1'b1; opcode = OP_SW; addr = 32'h44; wdata = 32'h12345678; step();
        valid = 1'b0; step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", req); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if ({ready, req, done} !== 3'b100) begin errors++; $display("FAIL rmid_reset got %b exp 100", {ready, req, done}); end
        ack = 1'b1; step(); ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({ready, req, done, err} !== 4'b1000) begin errors++; $display("FAIL rmid_stray got %b exp 1000", {ready, req, done, err}); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; opcode = OP_LW; addr = 32'h100; step();
        opcode = OP_SW; addr = 32'h200; wdata = 32'hCAFEF00D;
        checks++; if ({req, we, maddr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL b2b_first got %h exp 2_00000100", {req, we, maddr}); end
        step();
        checks++; if ({req, we, be, maddr} !== {6'b10_1111, 32'h100}) begin errors++; $display("FAIL b2b_hold got %h exp 2f_00000100", {req, we, be, maddr}); end
        ack = 1'b1; rdata = 32'h89ABCDEF; step(); ack = 1'b0;
        checks++; if ({done, err, rdval} !== {2'b10, 32'h89ABCDEF}) begin errors++; $display("FAIL b2b_done1 got %h exp 2_89abcdef", {done, err, rdval}); end
        step();
        checks++; if ({ready, req} !== 2'b10) begin errors++; $display("FAIL b2b_idle got %b exp 10", {ready, req}); end
        step(); valid = 1'b0;
        checks++; if ({req, we, maddr, mwdata} !== {2'b11, 32'h200, 32'hCAFEF00D}) begin errors++; $display("FAIL b2b_second got %h exp 3_00000200_cafef00d", {req, we, maddr, mwdata}); end
        ack = 1'b1; step(); ack = 1'b0;
        checks++; if ({done, err, rdval} !== {2'b10, 32'd0}) begin errors++; $display("FAIL b2b_done2 got %h exp 2_00000000", {done, err, rdval}); end
        step();
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, d, r;
        int          dly;
        for (int t = 0; t < 60; t++) begin
            op  = 4'($urandom_range(0, 9));
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
            d   = $urandom;
            r   = $urandom;
            dly = $urandom_range(0, 5);
            valid = 1'b1; opcode = op; addr = a; wdata = d; step();
            valid = 1'b0;
            if (!m_valid(op)) begin
                checks++; if ({ready, req, done} !== 3'b100) begin errors++; $display("FAIL rnd_ignore op=%0d got %b exp 100", op, {ready, req, done}); end
            end else if (m_mis(op, a)) begin
                checks++; if ({req, done, err, rdval} !== {3'b011, 32'd0}) begin errors++; $display("FAIL rnd_mis op=%0d a=%h got %h exp 3_00000000", op, a, {req, done, err, rdval}); end
                step();
            end else begin
                checks++;
                if ({req, we, be, maddr, mwdata} !== {1'b1, 1'(m_store(op)), m_be(op, a), a & 32'hFFFFFFFC, m_wd(op, d)}) begin
                    errors++;
                    $display("FAIL rnd_bus op=%0d a=%h got %h exp %h", op, a, {req, we, be, maddr, mwdata},
                             {1'b1, 1'(m_store(op)), m_be(op, a), a & 32'hFFFFFFFC, m_wd(op, d)});
                end
                for (int k = 0; k < TO; k++) begin
                    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rnd_reqhold k=%0d got %b exp 1", k, req); end
                    if (k == dly) begin ack = 1'b1; rdata = r; end
                    step();
                    ack = 1'b0;
                    if (k == dly) break;
                end
                checks++;
                if ({req, done, err, rdval} !== {2'b01, 1'(dly >= TO), (dly >= TO) ? 32'd0 : m_rd(op, a, r)}) begin
                    errors++;
                    $display("FAIL rnd_done op=%0d a=%h r=%h dly=%0d got %h exp %h", op, a, r, dly,
                             {req, done, err, rdval}, {2'b01, 1'(dly >= TO), (dly >= TO) ? 32'd0 : m_rd(op, a, r)});
                end
                step();
            end
            checks++; if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL rnd_idle got %b exp 100", {ready, busy, done}); end
        end
    endtask

    initial begin
        test_reset();
        test_lb_directed();
        test_sh_directed();
        test_misaligned();
        test_timeout();
        test_invalid_op();
        test_reset_mid_req();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32im_lsu_ctrl.md
RV32IM_LSU_CTRL -- requirements
Module: rv32im_lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum REQ-state cycles without mem_ack_i before the access aborts with error.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 lsu_valid_i  input  1  EXU presents a load/store this cycle.
REQ-005 lsu_opcode_i  input  `LSU_OPCODE_WIDTH  LB/LBU/LH/LHU/LW/SB/SH/SW.
REQ-006 addr_mem_i  input  `API_ADDR_WIDTH  byte address.
REQ-007 val_memwr_i  input  `API_DATA_WIDTH  store data, right-justified.
REQ-008 lsu_ready_o  output  1  controller idle; request accepted when lsu_valid_i && lsu_ready_o.
REQ-009 lsu_busy_o  output  1  access in flight; EXU stalls.
REQ-010 lsu_done_o  output  1  one-cycle completion pulse.
REQ-011 lsu_err_o  output  1  misaligned or timed-out access; valid only with lsu_done_o.
REQ-012 val_memrd_o  output  `API_DATA_WIDTH  extended load result; valid only with lsu_done_o on a load, else 0.
REQ-013 mem_req_o  output  1  bus request, held until ack or timeout.
REQ-014 mem_we_o  output  1  1 = write.
REQ-015 mem_be_o  output  4  byte-lane enables.
REQ-016 mem_addr_o  output  `API_ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
REQ-017 mem_wdata_o  output  `API_DATA_WIDTH  lane-positioned store data.
REQ-018 mem_ack_i  input  1  bus completes the access this cycle.
REQ-019 mem_rdata_i  input  `API_DATA_WIDTH  read word, valid with mem_ack_i.

Function
REQ-020 FSM states IDLE, REQ, RESP; lsu_ready_o = (state==IDLE), lsu_busy_o = (state!=IDLE).
REQ-021 IDLE: on accept of an aligned access, latch opcode, address, store data; go to REQ; mem_req_o high from the next cycle.
REQ-022 IDLE: opcode not a load/store -> request ignored, stay IDLE, no pulse.
REQ-023 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0 -> IDLE->RESP, no mem_req_o, lsu_err_o=1.
REQ-024 REQ: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o stable until exit; on mem_ack_i capture mem_rdata_i, go to RESP.
REQ-025 REQ: timeout counter clears on entry, increments each cycle without ack; ack arriving with counter == TIMEOUT_CYCLES-1 wins; otherwise reaching TIMEOUT_CYCLES -> RESP with lsu_err_o=1, mem_req_o dropped.
REQ-026 RESP: lsu_done_o=1 for exactly one cycle, then IDLE; minimum latency accept -> done = 2 cycles with zero-wait ack.
REQ-027 Byte enables: SB/LB/LBU 4'b0001<<addr[1:0]; SH/LH/LHU 4'b0011<<{addr[1],1'b0}; SW/LW 4'b1111; mem_we_o=1 for stores only.
REQ-028 Store data: SB byte replicated to all 4 lanes; SH halfword replicated to both halves; SW unchanged.
REQ-029 Load data: mem_rdata_i shifted right by 8*addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU) to `API_DATA_WIDTH; LW unchanged.
REQ-030 mem_ack_i outside REQ is ignored; lsu_valid_i outside IDLE is ignored (no queueing).
REQ-031 Outputs not qualified by state are 0 (mem_be_o, mem_wdata_o, mem_addr_o = 0 when mem_req_o=0).

Reset
REQ-032 rst_i high at an edge -> state IDLE, counter 0, all outputs 0 except lsu_ready_o=1 in the following cycle.
REQ-033 Reset mid-REQ drops mem_req_o next cycle with no lsu_done_o; a later stray ack is ignored.

Structure
REQ-034 Opcode encodings, `API_DATA_WIDTH, `API_ADDR_WIDTH and FSM state encodings live in the shared DEFINITIONS.v.
REQ-035 Lane alignment/extension logic (REQ-027..029) is one combinational sub-module rv32im_lsu_lane; the FSM and counter stay in rv32im_lsu_ctrl.

Verification
REQ-036 LB addr 0x1003, rdata 0x80AABBCC, ack same cycle as req -> be=4'b1000, addr 0x1000, done 2 cycles after accept, val_memrd_o=0xFFFFFF80.
REQ-037 SH addr 0x2002, data 0x0000BEEF -> we=1, be=4'b1100, wdata=0xBEEFBEEF, done, err=0.
REQ-038 LW addr 0x3001 -> no mem_req_o, done next+1 cycle, err=1, val_memrd_o=0.
REQ-039 LHU addr 0x0, ack withheld, TIMEOUT_CYCLES=4 -> req held 4 cycles, then dropped, done with err=1.
REQ-040 SW accepted, rst_i asserted second REQ cycle, ack pulsed after -> no done, ready=1, no new request.
REQ-041 Back-to-back valid while busy -> second request ignored until ready; reissued request completes normally.
